// File: rtl/result_scanner.sv
// result_scanner: snapshots candidate vote counts, converts each to BCD
// and sequences them onto a seven-segment display, then shows the winner.
module result_scanner #(
    parameter int NUM_CAND = 4,
    parameter int CNT_W    = 8,
    parameter int DIGITS   = 3,
    parameter int DWELL    = 16,
    parameter bit LZB      = 1'b0
) (
    input  logic                        c0,
    input  logic                        rst,
    input  logic                        s1,
    input  logic                        s2,
    input  logic [NUM_CAND*CNT_W-1:0]   res_bus,
    output logic [$clog2(NUM_CAND)-1:0] cand_idx,
    output logic [7*DIGITS-1:0]         seg_out,
    output logic                        disp_valid,
    output logic                        winner_phase,
    output logic                        tie,
    output logic                        round_done
);

    localparam int IW    = $clog2(NUM_CAND);
    localparam int BW    = $clog2(CNT_W) + 1;
    localparam int DW    = $clog2(DWELL) + 1;
    localparam int BCD_W = 4 * DIGITS;

    localparam logic [BW-1:0] BIT_LAST  = BW'(CNT_W - 1);
    localparam logic [DW-1:0] DW_LAST   = DW'(DWELL - 1);
    localparam logic [IW-1:0] CAND_LAST = IW'(NUM_CAND - 1);
    localparam logic [7*DIGITS-1:0] SEG_ZERO = {DIGITS{7'b0000001}};

    typedef enum logic [2:0] {
        IDLE,
        SNAP,
        CONV,
        SHOW,
        WIN
    } state_t;

    state_t                    state_q;
    logic [NUM_CAND*CNT_W-1:0] snap_q;
    logic [IW-1:0]             cand_q;
    logic [IW-1:0]             win_q;
    logic [CNT_W-1:0]          max_q;
    logic                      tie_r_q;
    logic [BCD_W-1:0]          bcd_q;
    logic [BCD_W-1:0]          bcd_d;
    logic [BCD_W-1:0]          win_bcd_q;
    logic [BW-1:0]             bit_q;
    logic [DW-1:0]             dwell_q;
    logic [7*DIGITS-1:0]       seg_q;
    logic                      dv_q;
    logic                      wp_q;
    logic                      tie_q;
    logic                      rd_q;

    logic                      mode_ok;
    logic [CNT_W-1:0]          cnt;

    assign mode_ok = !s1 && s2;

    assign cand_idx     = cand_q;
    assign seg_out      = seg_q;
    assign disp_valid   = dv_q;
    assign winner_phase = wp_q;
    assign tie          = tie_q;
    assign round_done   = rd_q;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = 7'b0000001;
        endcase
        return s;
    endfunction

    // Leading zeros blank only above the top nonzero digit; digit 0 always shows.
    function automatic logic [7*DIGITS-1:0] to_seg(input logic [BCD_W-1:0] b);
        logic [7*DIGITS-1:0] s;
        logic                nz;
        s  = '0;
        nz = 1'b0;
        for (int d = DIGITS - 1; d >= 0; d--) begin
            if (b[4*d +: 4] != 4'd0) nz = 1'b1;
            if (LZB && !nz && d != 0) s[7*d +: 7] = 7'b1111111;
            else                      s[7*d +: 7] = seg7(b[4*d +: 4]);
        end
        return s;
    endfunction

    // Count of the candidate currently selected from the snapshot.
    always_comb begin
        cnt = snap_q[int'(cand_q)*CNT_W +: CNT_W];
    end

    // One double-dabble step: add-3 correction, then shift in the next bit MSB first.
    always_comb begin
        bcd_d = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_d[4*i +: 4] >= 4'd5) bcd_d[4*i +: 4] = bcd_d[4*i +: 4] + 4'd3;
        end
        bcd_d = {bcd_d[BCD_W-2:0], cnt[CNT_W-1-int'(bit_q)]};
    end

    // Sequencer FSM with registered display outputs and winner tracking.
    always_ff @(posedge c0) begin
        if (rst || !mode_ok) begin
            state_q   <= IDLE;
            snap_q    <= '0;
            cand_q    <= '0;
            win_q     <= '0;
            max_q     <= '0;
            tie_r_q   <= 1'b0;
            bcd_q     <= '0;
            win_bcd_q <= '0;
            bit_q     <= '0;
            dwell_q   <= '0;
            seg_q     <= SEG_ZERO;
            dv_q      <= 1'b0;
            wp_q      <= 1'b0;
            tie_q     <= 1'b0;
            rd_q      <= 1'b0;
        end else begin
            rd_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    state_q <= SNAP;
                end
                SNAP: begin
                    snap_q    <= res_bus;
                    cand_q    <= '0;
                    win_q     <= '0;
                    max_q     <= '0;
                    tie_r_q   <= 1'b0;
                    win_bcd_q <= '0;
                    bcd_q     <= '0;
                    bit_q     <= '0;
                    dv_q      <= 1'b0;
                    wp_q      <= 1'b0;
                    tie_q     <= 1'b0;
                    state_q   <= CONV;
                end
                CONV: begin
                    bcd_q <= bcd_d;
                    if (bit_q == BIT_LAST) begin
                        bit_q   <= '0;
                        dwell_q <= '0;
                        state_q <= SHOW;
                    end else begin
                        bit_q <= bit_q + 1'b1;
                    end
                end
                SHOW: begin
                    if (dwell_q == '0) begin
                        seg_q <= to_seg(bcd_q);
                        dv_q  <= 1'b1;
                        if (cnt > max_q) begin
                            max_q     <= cnt;
                            win_q     <= cand_q;
                            win_bcd_q <= bcd_q;
                            tie_r_q   <= 1'b0;
                        end else if (cnt == max_q && cand_q != '0) begin
                            tie_r_q <= 1'b1;
                        end
                    end
                    if (dwell_q == DW_LAST) begin
                        dwell_q <= '0;
                        if (cand_q == CAND_LAST) begin
                            state_q <= WIN;
                        end else begin
                            cand_q  <= cand_q + 1'b1;
                            bcd_q   <= '0;
                            bit_q   <= '0;
                            state_q <= CONV;
                        end
                    end else begin
                        dwell_q <= dwell_q + 1'b1;
                    end
                end
                WIN: begin
                    if (dwell_q == '0) begin
                        cand_q <= win_q;
                        seg_q  <= to_seg(win_bcd_q);
                        wp_q   <= 1'b1;
                        tie_q  <= tie_r_q;
                    end
                    if (dwell_q == DW_LAST) begin
                        dwell_q <= '0;
                        rd_q    <= 1'b1;
                        state_q <= SNAP;
                    end else begin
                        dwell_q <= dwell_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
